vga_fb_reader: RTL and testbench

- Downstream of the VGA timing generator.
- Consumes h_sync, v_sync, x_loc and y_loc on clk_108Mhz and reads a down-scaled, double-buffered framebuffer from an external synchronous RAM.
- Drives 12-bit RGB to the DAC pins, with syncs delayed to stay pixel-aligned.
- Handles the front/back buffer swap handshake with the drawing logic, committed only at the start of vertical blanking.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_fb_reader.sv | 134 +++++++++++++
 tb/tb_vga_fb_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer reader: timing defaults, RGB444
// field layout, framebuffer geometry helpers and the swap FSM state type.
package vga_pkg;

  localparam int DEF_H_RES   = 1280;
  localparam int DEF_V_RES   = 1024;
  localparam int H_FRONT     = 48;
  localparam int H_SYNC_LEN  = 112;
  localparam int H_BACK      = 248;
  localparam int H_TOTAL     = DEF_H_RES + H_FRONT + H_SYNC_LEN + H_BACK;
  localparam int V_FRONT     = 1;
  localparam int V_SYNC_LEN  = 3;
  localparam int V_BACK      = 38;
  localparam int V_TOTAL     = DEF_V_RES + V_FRONT + V_SYNC_LEN + V_BACK;

  localparam int RGB_R_LSB   = 8;
  localparam int RGB_G_LSB   = 4;
  localparam int RGB_B_LSB   = 0;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  function automatic int fb_w(input int h_res, input int scale_shift);
    return h_res >> scale_shift;
  endfunction

  function automatic int fb_size(input int h_res, input int v_res, input int scale_shift);
    return fb_w(h_res, scale_shift) * (v_res >> scale_shift);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep syncs and flags aligned with the
// RAM read pipeline.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Reads a down-scaled, double-buffered framebuffer in step with the VGA
// timing counters and drives pixel-aligned RGB444 plus delayed syncs.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int SCALE_SHIFT = 2,
  parameter int RAM_LAT     = 1,
  parameter int ADDR_W      = 18,
  parameter int PIX_W       = 12
) (
  input  logic              clk_108Mhz,
  input  logic              rst_n,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [10:0]       x_loc,
  input  logic [10:0]       y_loc,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [PIX_W-1:0]  ram_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
);

  localparam int FB_W    = fb_w(H_RES, SCALE_SHIFT);
  localparam int FB_SIZE = fb_size(H_RES, V_RES, SCALE_SHIFT);

  logic [10:0]       x_s0, y_s0;
  logic              act_s0, hs_s0, vs_s0, fs_s0;
  logic              act_in, at_commit;
  logic [ADDR_W-1:0] addr_next;
  logic              act_d, hs_d, vs_d, fs_d;
  swap_state_t       state, state_next;
  logic              commit;

  assign act_in    = (x_loc < 11'(H_RES)) && (y_loc < 11'(V_RES));
  assign at_commit = (x_loc == 11'd0) && (y_loc == 11'(V_RES));

  always_ff @(posedge clk_108Mhz or negedge rst_n) begin
    if (!rst_n) begin
      x_s0   <= '0;
      y_s0   <= '0;
      act_s0 <= 1'b0;
      hs_s0  <= 1'b0;
      vs_s0  <= 1'b0;
      fs_s0  <= 1'b0;
    end else begin
      x_s0   <= x_loc;
      y_s0   <= y_loc;
      act_s0 <= act_in;
      hs_s0  <= h_sync_in;
      vs_s0  <= v_sync_in;
      fs_s0  <= (x_loc == 11'd0) && (y_loc == 11'd0);
    end
  end

  // Buffer base comes from front_sel here only, so a commit in blanking can never split a frame.
  assign addr_next = (front_sel ? ADDR_W'(FB_SIZE) : '0)
                   + ADDR_W'(y_s0 >> SCALE_SHIFT) * ADDR_W'(FB_W)
                   + ADDR_W'(x_s0 >> SCALE_SHIFT);

  always_ff @(posedge clk_108Mhz or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
    end else begin
      ram_rd_en <= act_s0;
      if (act_s0) ram_addr <= addr_next;
    end
  end

  vga_delay_line #(
    .WIDTH (4),
    .DEPTH (RAM_LAT + 1)
  ) u_align (
    .clk   (clk_108Mhz),
    .rst_n (rst_n),
    .d     ({hs_s0, vs_s0, act_s0, fs_s0}),
    .q     ({hs_d, vs_d, act_d, fs_d})
  );

  always_ff @(posedge clk_108Mhz or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= act_d ? ram_rdata[RGB_R_LSB +: 4] : 4'd0;
      vga_g       <= act_d ? ram_rdata[RGB_G_LSB +: 4] : 4'd0;
      vga_b       <= act_d ? ram_rdata[RGB_B_LSB +: 4] : 4'd0;
      h_sync      <= hs_d;
      v_sync      <= vs_d;
      frame_start <= fs_d;
    end
  end

  // A request arriving on the commit cycle itself waits for the next frame.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      SWAP_IDLE:    if (swap_req) state_next = SWAP_PENDING;
      SWAP_PENDING: if (at_commit) begin
        commit     = 1'b1;
        state_next = SWAP_IDLE;
      end
      default:      state_next = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_108Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SWAP_IDLE;
      swap_ack  <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      state    <= state_next;
      swap_ack <= commit;
      if (commit) front_sel <= ~front_sel;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomized bench for vga_fb_reader: a per-input reference record predicts
// every pin from the frame geometry, a hashed RAM image and the swap rules.
module tb_vga_fb_reader;
  import vga_pkg::*;

  localparam int H    = 1280;
  localparam int V    = 1024;
  localparam int FBW  = H / 4;
  localparam int FBS  = FBW * (V / 4);
  localparam int NREC = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        h_sync_in, v_sync_in, swap_req;
  logic [10:0] x_loc, y_loc;
  logic [17:0] ram_addr;
  logic        ram_rd_en;
  logic [11:0] ram_rdata;
  logic        swap_ack, front_sel;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        h_sync, v_sync, frame_start;

  typedef struct {
    int x, y, addr;
    bit hs, vs, req, bub, act, fs, ack, front;
  } rec_t;

  rec_t hist [NREC];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_pending = 0;
  bit   m_front = 0;

  vga_fb_reader dut (
    .clk_108Mhz  (clk),
    .rst_n       (rst_n),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .x_loc       (x_loc),
    .y_loc       (y_loc),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rdata   (ram_rdata),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_sel   (front_sel),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic int ram_data(input int a);
    if (a == 641) return 'hA5C;
    return ((a * 37) ^ (a >> 3)) & 'hFFF;
  endfunction

  // External RAM image with one cycle of latency; it returns junk when not strobed.
  always @(posedge clk) ram_rdata <= ram_rd_en ? 12'(ram_data(int'(ram_addr))) : 12'hFFF;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (input #%0d)", tag, got, want, cyc);
    end
  endtask

  function automatic rec_t get_rec(input int i);
    rec_t r;
    if (i < 0) begin
      r = '{default: 0};
      r.bub = 1'b1;
    end else begin
      r = hist[i];
    end
    return r;
  endfunction

  task automatic eval_record(input int i);
    hist[i].bub = !rst_n;
    hist[i].act = 1'b0;
    hist[i].fs  = 1'b0;
    hist[i].ack = 1'b0;
    if (rst_n) begin
      hist[i].act = (hist[i].x < H) && (hist[i].y < V);
      hist[i].fs  = (hist[i].x == 0) && (hist[i].y == 0);
      if (m_pending && hist[i].x == 0 && hist[i].y == V) begin
        m_front     = !m_front;
        m_pending   = 1'b0;
        hist[i].ack = 1'b1;
      end else if (hist[i].req) begin
        m_pending = 1'b1;
      end
    end
    hist[i].front = m_front;
    hist[i].addr  = (m_front ? FBS : 0) + (hist[i].y / 4) * FBW + hist[i].x / 4;
  endtask

  // Outputs after edge m reflect: ack/front of input m, RAM request of m-1, pixel of m-3.
  task automatic check_cycle(input int m);
    rec_t r0, r1, r3;
    int   exp_rgb;
    r0 = get_rec(m);
    r1 = get_rec(m - 1);
    r3 = get_rec(m - 3);
    check_output("swap_ack", 32'(swap_ack), 32'(r0.ack));
    check_output("front_sel", 32'(front_sel), 32'(r0.front));
    check_output("ram_rd_en", 32'(ram_rd_en), 32'(r1.act));
    if (r1.act) check_output("ram_addr", 32'(ram_addr), r1.addr);
    exp_rgb = r3.act ? ram_data(r3.addr) : 0;
    check_output("rgb", 32'({vga_r, vga_g, vga_b}), exp_rgb);
    check_output("sync_fs", 32'({h_sync, v_sync, frame_start}),
                 r3.bub ? 32'd0 : 32'({r3.hs, r3.vs, r3.fs}));
  endtask

  task automatic apply_stimulus(input int x, input int y, input bit hs, input bit vs, input bit req);
    @(negedge clk);
    check_cycle(cyc - 1);
    if (cyc >= NREC) begin
      $display("[TB] FAIL record_overflow: got %0d, want < %0d", cyc, NREC);
      $fatal(1, "[TB] record table exhausted");
    end
    x_loc     = 11'(x);
    y_loc     = 11'(y);
    h_sync_in = hs;
    v_sync_in = vs;
    swap_req  = req;
    hist[cyc].x   = x;
    hist[cyc].y   = y;
    hist[cyc].hs  = hs;
    hist[cyc].vs  = vs;
    hist[cyc].req = req;
    eval_record(cyc);
    cyc++;
  endtask

  task automatic set_reset_low();
    rst_n = 1'b0;
    #1;
    check_output("reset_addr", 32'(ram_addr), 32'd0);
    check_output("reset_pins", 32'({ram_rd_en, swap_ack, front_sel, vga_r, vga_g, vga_b,
                                    h_sync, v_sync, frame_start}), 32'd0);
    for (int i = (cyc >= 4 ? cyc - 4 : 0); i < cyc; i++) begin
      hist[i].bub   = 1'b1;
      hist[i].act   = 1'b0;
      hist[i].fs    = 1'b0;
      hist[i].ack   = 1'b0;
      hist[i].front = 1'b0;
    end
    m_pending = 1'b0;
    m_front   = 1'b0;
  endtask

  task automatic set_reset_high();
    rst_n = 1'b1;
    if (cyc > 0) eval_record(cyc - 1);
  endtask

  initial begin
    int r, x, y;
    rst_n     = 1'b0;
    x_loc     = '0;
    y_loc     = '0;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    swap_req  = 1'b0;
    #1;
    check_output("reset_addr", 32'(ram_addr), 32'd0);
    check_output("reset_pins", 32'({ram_rd_en, swap_ack, front_sel, vga_r, vga_g, vga_b,
                                    h_sync, v_sync, frame_start}), 32'd0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
    set_reset_high();

    apply_stimulus(5, 9, 0, 0, 0);
    apply_stimulus(1280, 0, 1, 0, 0);
    apply_stimulus(1281, 0, 1, 0, 0);
    check_output("addr_5_9", 32'(ram_addr), 32'd641);
    check_output("rd_en_5_9", 32'(ram_rd_en), 32'd1);
    apply_stimulus(1282, 0, 0, 0, 0);
    apply_stimulus(1283, 0, 0, 0, 0);
    check_output("rgb_A5C", 32'({vga_r, vga_g, vga_b}), 32'hA5C);

    apply_stimulus(10, 500, 0, 0, 1);
    for (int i = 0; i < 6; i++) apply_stimulus(20 + i * 100, 501 + i * 80, 0, 0, 0);
    apply_stimulus(0, V, 0, 1, 0);
    apply_stimulus(1, V, 0, 1, 0);
    check_output("ack_commit", 32'(swap_ack), 32'd1);
    check_output("front_after", 32'(front_sel), 32'd1);
    apply_stimulus(5, 9, 0, 0, 0);
    apply_stimulus(1300, 9, 1, 0, 0);
    apply_stimulus(1301, 9, 1, 0, 0);
    check_output("addr_back", 32'(ram_addr), 32'd82561);

    apply_stimulus(3, 100, 0, 0, 1);
    apply_stimulus(7, 200, 0, 0, 1);
    apply_stimulus(0, V, 0, 0, 0);
    apply_stimulus(9, 50, 0, 0, 0);
    apply_stimulus(0, V, 0, 0, 0);

    apply_stimulus(0, V, 0, 0, 1);
    apply_stimulus(40, 40, 0, 0, 0);
    apply_stimulus(0, V, 0, 0, 0);

    apply_stimulus(100, 300, 0, 0, 1);
    apply_stimulus(101, 300, 0, 0, 0);
    set_reset_low();
    apply_stimulus(102, 300, 1, 1, 0);
    apply_stimulus(103, 300, 1, 1, 0);
    set_reset_high();
    apply_stimulus(0, V, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    repeat (4) apply_stimulus(1290, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        x = $urandom_range(0, H - 1);
        y = $urandom_range(0, V - 1);
      end else if (r < 78) begin
        x = 0;
        y = V;
      end else if (r < 82) begin
        x = 0;
        y = 0;
      end else begin
        x = $urandom_range(0, H_TOTAL - 1);
        y = $urandom_range(0, V_TOTAL - 1);
      end
      apply_stimulus(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 99) < 6);
      if ($urandom_range(0, 499) == 0) begin
        set_reset_low();
        repeat (2) apply_stimulus($urandom_range(0, H - 1), $urandom_range(0, V - 1), 1, 1, 1);
        set_reset_high();
      end
    end

    repeat (5) apply_stimulus(1300, 1030, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
